// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and FSM state encoding for the binary-to-BCD converter.
// Used by both the top level and the add-3 digit correction cell.
package bin_to_bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADD3_THRESH = 4'd5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift,
// so that the shift carries correctly into the next decimal digit.
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_ADD3_THRESH) begin
            o_digit = i_digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (one bit per clock) with saturation and a
// leading-zero mask; results are held stable between conversions for the display.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          binary,
    output logic                          busy,
    output logic                          done,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
    output logic                          overflow,
    output logic [DIGITS-1:0]             digit_valid
);

    localparam int SCR_DIGITS = DIGITS + 1;
    localparam int SCR_W      = SCR_DIGITS * BCD_DIGIT_W;
    localparam int OUT_W      = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W      = $clog2(BIN_WIDTH);
    localparam logic [31:0]      MAX_VAL   = 32'(10**DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);
    localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t               r_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [SCR_W-1:0]     r_scratch;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf_pending;
    logic                 r_done;
    logic [OUT_W-1:0]     r_bcd;
    logic                 r_overflow;
    logic [DIGITS-1:0]    r_digit_valid;

    state_t               w_state_next;
    logic [BIN_WIDTH-1:0] w_shift_next;
    logic [SCR_W-1:0]     w_scratch_next;
    logic [CNT_W-1:0]     w_count_next;
    logic                 w_ovf_pending_next;
    logic                 w_done_next;
    logic [OUT_W-1:0]     w_bcd_next;
    logic                 w_overflow_next;
    logic [DIGITS-1:0]    w_digit_valid_next;

    logic [SCR_W-1:0]     w_adj;
    logic [SCR_W-1:0]     w_scratch_shifted;
    logic [BIN_WIDTH-1:0] w_shift_shifted;
    logic [OUT_W-1:0]     w_result;
    logic [DIGITS-1:0]    w_nonzero;
    logic [DIGITS-1:0]    w_result_valid;

    // Correct every scratch digit (including the internal overflow digit) in parallel.
    generate
        for (genvar gi = 0; gi < SCR_DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // {scratch, shift} shifts left as one combined register.
    assign w_scratch_shifted = {w_adj[SCR_W-2:0], r_shift[BIN_WIDTH-1]};
    assign w_shift_shifted   = {r_shift[BIN_WIDTH-2:0], 1'b0};
    assign w_result          = w_scratch_shifted[OUT_W-1:0];

    // Digit k is shown when any digit at or above k is nonzero; digit 0 always shows.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_valid
            assign w_nonzero[gi] = |w_result[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
            if (gi == 0) begin : g_lsd
                assign w_result_valid[gi] = 1'b1;
            end else begin : g_upper
                assign w_result_valid[gi] = |w_nonzero[DIGITS-1:gi];
            end
        end
    endgenerate

    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_scratch_next     = r_scratch;
        w_count_next       = r_count;
        w_ovf_pending_next = r_ovf_pending;
        w_done_next        = 1'b0;
        w_bcd_next         = r_bcd;
        w_overflow_next    = r_overflow;
        w_digit_valid_next = r_digit_valid;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_shift_next       = binary;
                    w_ovf_pending_next = 32'(binary) > MAX_VAL;
                    w_scratch_next     = '0;
                    w_count_next       = '0;
                    w_state_next       = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_scratch_next = w_scratch_shifted;
                w_shift_next   = w_shift_shifted;
                w_count_next   = r_count + CNT_W'(1);
                if (r_count == LAST_ITER) begin
                    w_count_next = '0;
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    // Saturated values still run the full conversion for fixed latency.
                    if (r_ovf_pending) begin
                        w_bcd_next         = ALL_NINES;
                        w_overflow_next    = 1'b1;
                        w_digit_valid_next = '1;
                    end else begin
                        w_bcd_next         = w_result;
                        w_overflow_next    = 1'b0;
                        w_digit_valid_next = w_result_valid;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_scratch     <= '0;
            r_count       <= '0;
            r_ovf_pending <= 1'b0;
            r_done        <= 1'b0;
            r_bcd         <= '0;
            r_overflow    <= 1'b0;
            r_digit_valid <= DIGITS'(1);
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_scratch     <= w_scratch_next;
            r_count       <= w_count_next;
            r_ovf_pending <= w_ovf_pending_next;
            r_done        <= w_done_next;
            r_bcd         <= w_bcd_next;
            r_overflow    <= w_overflow_next;
            r_digit_valid <= w_digit_valid_next;
        end
    end

    assign busy        = (r_state == ST_CONVERT);
    assign done        = r_done;
    assign bcd         = r_bcd;
    assign overflow    = r_overflow;
    assign digit_valid = r_digit_valid;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed vector table, multi-cycle corner
// sequences, and random values checked against a decimal-arithmetic reference.
module tb_bin_to_bcd;

    localparam int BIN_WIDTH = 14;
    localparam int DIGITS    = 4;
    localparam int LATENCY   = BIN_WIDTH + 1;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [BIN_WIDTH-1:0] binary;
    logic                 busy;
    logic                 done;
    logic [15:0]          bcd;
    logic                 overflow;
    logic [DIGITS-1:0]    digit_valid;

    int checks;
    int failures;
    int stable_err;

    bin_to_bcd #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .binary      (binary),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .overflow    (overflow),
        .digit_valid (digit_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BIN_WIDTH-1:0] bin;
        logic [15:0]          exp_bcd;
        logic [3:0]           exp_dv;
        logic                 exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, saturating above 9999.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        if (v > 9999) return 16'h9999;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_dv(input int v);
        int nd;
        if (v > 9999) return 4'hf;
        nd = 1;
        if (v >= 10)   nd = 2;
        if (v >= 100)  nd = 3;
        if (v >= 1000) nd = 4;
        return 4'((1 << nd) - 1);
    endfunction

    // Start a conversion and wait for done; lat is start cycle to done cycle.
    task automatic do_convert(input logic [BIN_WIDTH-1:0] v, output int lat);
        logic [15:0] prev;
        lat = -1;
        prev = bcd;
        binary = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        binary = BIN_WIDTH'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i + 2;
                break;
            end
            if (bcd !== prev) stable_err++;
        end
        $display("conv bin=%0d bcd=%h ovf=%0b dv=%b lat=%0d", v, bcd, overflow, digit_valid, lat);
    endtask

    vec_t vecs[10];
    int   lat;
    int   dcount;
    logic [15:0] got;

    initial begin
        checks = 0;
        failures = 0;
        stable_err = 0;
        clk = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        binary = '0;

        vecs[0] = '{14'd0,     16'h0000, 4'b0001, 1'b0};
        vecs[1] = '{14'd1234,  16'h1234, 4'b1111, 1'b0};
        vecs[2] = '{14'd42,    16'h0042, 4'b0011, 1'b0};
        vecs[3] = '{14'd9999,  16'h9999, 4'b1111, 1'b0};
        vecs[4] = '{14'd10000, 16'h9999, 4'b1111, 1'b1};
        vecs[5] = '{14'd16383, 16'h9999, 4'b1111, 1'b1};
        vecs[6] = '{14'd7,     16'h0007, 4'b0001, 1'b0};
        vecs[7] = '{14'd305,   16'h0305, 4'b0111, 1'b0};
        vecs[8] = '{14'd100,   16'h0100, 4'b0111, 1'b0};
        vecs[9] = '{14'd8192,  16'h8192, 4'b1111, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_dv", 32'(digit_valid), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_convert(vecs[i].bin, lat);
            check("vec_bcd", 32'(bcd), 32'(vecs[i].exp_bcd));
            check("vec_dv", 32'(digit_valid), 32'(vecs[i].exp_dv));
            check("vec_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
            check("vec_latency", 32'(lat), 32'(LATENCY));
            check("vec_busy_at_done", 32'(busy), 32'd0);
        end

        // Back-to-back: start in the done cycle of 7 gives 305 fifteen cycles later.
        do_convert(14'd7, lat);
        check("b2b_first_bcd", 32'(bcd), 32'h0007);
        do_convert(14'd305, lat);
        check("b2b_second_bcd", 32'(bcd), 32'h0305);
        check("b2b_period", 32'(lat), 32'(LATENCY));

        // Start while busy must be ignored, not queued.
        @(posedge clk);
        #1;
        binary = 14'd1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        binary = '0;
        dcount = 0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) begin
                start = 1'b1;
                binary = 14'd77;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                got = bcd;
            end
        end
        start = 1'b0;
        $display("busy_start done_pulses=%0d bcd=%h", dcount, got);
        check("ignored_start_pulses", 32'(dcount), 32'd1);
        check("ignored_start_bcd", 32'(got), 32'h1234);

        // Reset during a conversion aborts it with no done pulse.
        binary = 14'd1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dv", 32'(digit_valid), 32'd1);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        $display("abort done_pulses=%0d", dcount);
        check("abort_no_done", 32'(dcount), 32'd0);
        do_convert(14'd56, lat);
        check("after_abort_bcd", 32'(bcd), 32'h0056);
        check("after_abort_latency", 32'(lat), 32'(LATENCY));

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        binary = 14'd99;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        $display("reset_and_start done_pulses=%0d bcd=%h", dcount, bcd);
        check("rst_start_no_done", 32'(dcount), 32'd0);
        check("rst_start_bcd", 32'(bcd), 32'd0);

        // Random values against the decimal reference.
        for (int i = 0; i < 150; i++) begin
            int v;
            v = int'($urandom_range(0, 16383));
            do_convert(BIN_WIDTH'(v), lat);
            check("rand_bcd", 32'(bcd), 32'(ref_bcd(v)));
            check("rand_dv", 32'(digit_valid), 32'(ref_dv(v)));
            check("rand_ovf", 32'(overflow), (v > 9999) ? 32'd1 : 32'd0);
            check("rand_latency", 32'(lat), 32'(LATENCY));
        end

        check("bcd_stable_while_busy", 32'(stable_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
